dmem_sram_like_if: RTL and testbench

- M-stage data-memory bus master placed directly downstream of the load/store byte-select and alignment stage.
- Takes the aligned request from that stage: byte enables, replicated write data, access size and address.
- Runs one SRAM-like transaction per memory instruction, issuing the address phase and then collecting the data phase.
- Stalls the pipeline until the transaction completes and holds the raw read word for the load-extension logic.

---
 rtl/dmem_sram_like_if_if.sv | 21 ++
 rtl/dmem_sram_like_if.sv | 121 ++++++++++++
 tb/tb_dmem_sram_like_if.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_sram_like_if_if.sv
// rtl/dmem_sram_like_if_if.sv - SRAM-like data bus between the M-stage master and memory
interface dmem_sram_like_if_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/dmem_sram_like_if.sv
// rtl/dmem_sram_like_if.sv - M-stage data-memory master: one SRAM-like transaction per load/store,
// stalling the pipe until the data phase completes and holding the raw read word.
module dmem_sram_like_if #(
  parameter bit MAP_KSEG = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_mem_en,
  input  logic [3:0]  i_mem_sel,
  input  logic [1:0]  i_mem_size,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  input  logic        i_mem_except,
  input  logic        i_flush,
  input  logic        i_pipe_stall,
  output logic        o_stall,
  output logic [31:0] o_rdata,
  dmem_sram_like_if_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_cancel;
  logic [31:0] r_rdata;
  logic        w_start;
  logic        w_in_idle;
  logic [31:0] w_addr;

  // rst gates start so a reset mid-instruction drops the request in the same cycle
  assign w_in_idle = (r_state == S_IDLE);
  assign w_start   = w_in_idle & i_mem_en & ~i_mem_except & ~i_flush & ~rst;

  always_comb begin
    w_addr = i_mem_addr;
    if (MAP_KSEG && (i_mem_addr[31:30] == 2'b10)) begin
      w_addr = {3'b000, i_mem_addr[28:0]};
    end
  end

  assign bus.data_addr  = w_addr;
  assign bus.data_size  = i_mem_size;
  assign bus.data_wdata = i_mem_wdata;
  assign o_rdata        = r_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cancel <= 1'b0;
      r_rdata  <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_next == S_IDLE) begin
        r_cancel <= 1'b0;
      end else if (((r_state == S_ADDR) || (r_state == S_WAIT)) && i_flush) begin
        r_cancel <= 1'b1;
      end
      if ((r_state == S_WAIT) && bus.data_data_ok) begin
        r_rdata <= bus.data_rdata;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next = bus.data_addr_ok ? S_WAIT : S_ADDR;
        end
      end
      S_ADDR: begin
        if (bus.data_addr_ok) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        // a flush arriving together with data_ok still discards the result
        if (bus.data_data_ok) begin
          w_next = (r_cancel | i_flush) ? S_IDLE : S_DONE;
        end
      end
      S_DONE: begin
        if (~i_pipe_stall | i_flush) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.data_req = 1'b0;
    o_stall      = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.data_req = w_start;
        o_stall      = w_start;
      end
      S_ADDR: begin
        bus.data_req = 1'b1;
        o_stall      = 1'b1;
      end
      S_WAIT: begin
        o_stall = 1'b1;
      end
      default: begin
        bus.data_req = 1'b0;
        o_stall      = 1'b0;
      end
    endcase
    bus.data_wr = bus.data_req & (|i_mem_sel);
  end

endmodule

// File: tb/tb_dmem_sram_like_if.sv
// tb/tb_dmem_sram_like_if.sv - bench for dmem_sram_like_if: directed bus scenarios plus
// randomized traffic compared against a transaction-level model.
module tb_dmem_sram_like_if;
  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  sel;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        exc;
  logic        flush;
  logic        pstall;
  logic        aok;
  logic        dok;
  logic [31:0] rdat;
  logic        stall0, stall1;
  logic [31:0] rd0, rd1;

  int total = 0;
  int bad   = 0;

  // model: transaction outstanding, address accepted, cancelled, result held
  logic        m_busy, m_acc, m_cancel, m_done;
  logic [31:0] m_rdata;

  dmem_sram_like_if_if bus0 ();
  dmem_sram_like_if_if bus1 ();

  assign bus0.data_addr_ok = aok;
  assign bus0.data_data_ok = dok;
  assign bus0.data_rdata   = rdat;
  assign bus1.data_addr_ok = aok;
  assign bus1.data_data_ok = dok;
  assign bus1.data_rdata   = rdat;

  dmem_sram_like_if #(.MAP_KSEG(1'b1)) u0 (
    .clk(clk), .rst(rst), .i_mem_en(en), .i_mem_sel(sel), .i_mem_size(size),
    .i_mem_addr(addr), .i_mem_wdata(wdata), .i_mem_except(exc), .i_flush(flush),
    .i_pipe_stall(pstall), .o_stall(stall0), .o_rdata(rd0), .bus(bus0)
  );

  dmem_sram_like_if #(.MAP_KSEG(1'b0)) u1 (
    .clk(clk), .rst(rst), .i_mem_en(en), .i_mem_sel(sel), .i_mem_size(size),
    .i_mem_addr(addr), .i_mem_wdata(wdata), .i_mem_except(exc), .i_flush(flush),
    .i_pipe_stall(pstall), .o_stall(stall1), .o_rdata(rd1), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] phys(input logic [31:0] a);
    if (a >= 32'h8000_0000 && a < 32'hA000_0000) return a - 32'h8000_0000;
    if (a >= 32'hA000_0000 && a < 32'hC000_0000) return a - 32'hA000_0000;
    return a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_req();
    logic st;
    st = en & ~exc & ~flush & ~rst & ~m_busy & ~m_done;
    return st | (m_busy & ~m_acc & ~rst);
  endfunction

  // the single compare point: every cycle, #1 after inputs change at negedge
  task automatic settle();
    logic e_start, e_req, e_stall, e_wr;
    #1;
    if (rst) begin
      m_busy = 0; m_acc = 0; m_cancel = 0; m_done = 0; m_rdata = 0;
    end
    e_start = en & ~exc & ~flush & ~rst & ~m_busy & ~m_done;
    e_req   = e_start | (m_busy & ~m_acc);
    e_stall = e_start | m_busy;
    e_wr    = e_req & (sel != 4'd0);
    chk("req",    bus0.data_req, e_req);
    chk("wr",     bus0.data_wr, e_wr);
    chk("stall",  stall0, e_stall);
    chk("rdata",  rd0, m_rdata);
    chk("addr",   bus0.data_addr, phys(addr));
    chk("size",   bus0.data_size, size);
    chk("wdata",  bus0.data_wdata, wdata);
    chk("addr_nomap", bus1.data_addr, addr);
    chk("req_nomap",  bus1.data_req, e_req);
    chk("stall_nomap", stall1, e_stall);
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_acc = 0; m_cancel = 0; m_done = 0; m_rdata = 0;
    end else if (m_done) begin
      if (!pstall || flush) m_done = 0;
    end else if (m_busy && !m_acc) begin
      if (flush) m_cancel = 1;
      if (aok) m_acc = 1;
    end else if (m_busy) begin
      if (dok) begin
        m_rdata  = rdat;
        m_done   = !(m_cancel || flush);
        m_busy   = 0;
        m_acc    = 0;
        m_cancel = 0;
      end else if (flush) begin
        m_cancel = 1;
      end
    end else if (en && !exc && !flush) begin
      m_busy   = 1;
      m_acc    = aok;
      m_cancel = 0;
    end
    @(negedge clk);
  endtask

  task automatic set_m(input logic e, input logic [3:0] s, input logic [1:0] z,
                       input logic [31:0] a, input logic [31:0] w, input logic x);
    en = e; sel = s; size = z; addr = a; wdata = w; exc = x;
  endtask

  task automatic quiet();
    flush = 0; pstall = 0; aok = 0; dok = 0; rdat = 32'h0; rst = 0;
  endtask

  logic [3:0] segs [6];

  initial begin
    segs = '{4'h8, 4'h9, 4'hA, 4'hB, 4'h0, 4'hC};
    m_busy = 0; m_acc = 0; m_cancel = 0; m_done = 0; m_rdata = 0;
    quiet();
    rst = 1;
    set_m(0, 4'h0, 2'd0, 32'h0, 32'h0, 0);
    settle();
    chk("reset_stall", stall0, 1'b0);
    chk("reset_req", bus0.data_req, 1'b0);
    chk("reset_rdata", rd0, 32'h0);
    advance();
    rst = 0;
    settle(); advance();

    chk("model_kseg1", phys(32'hBFC0_0002), 32'h1FC0_0002);
    chk("model_kseg0", phys(32'h8000_0010), 32'h0000_0010);

    // lw, zero-wait bus
    set_m(1, 4'h0, 2'd2, 32'h8000_0010, 32'h0, 0); aok = 1;
    settle();
    chk("lw_req", bus0.data_req, 1'b1);
    chk("lw_wr", bus0.data_wr, 1'b0);
    chk("lw_addr", bus0.data_addr, 32'h0000_0010);
    chk("lw_addr_nomap", bus1.data_addr, 32'h8000_0010);
    chk("lw_stall_n", stall0, 1'b1);
    advance();
    aok = 0; dok = 1; rdat = 32'hDEAD_BEEF;
    settle(); chk("lw_stall_n1", stall0, 1'b1); advance();
    dok = 0; rdat = 32'h0;
    settle();
    chk("lw_stall_n2", stall0, 1'b0);
    chk("lw_rdata", rd0, 32'hDEAD_BEEF);
    advance();
    en = 0; settle(); advance();

    // sb, addr_ok delayed three cycles
    set_m(1, 4'b0100, 2'd0, 32'hBFC0_0002, 32'h5A5A_5A5A, 0);
    for (int i = 0; i < 4; i++) begin
      aok = (i == 3);
      settle();
      chk("sb_req_held", bus0.data_req, 1'b1);
      chk("sb_wr", bus0.data_wr, 1'b1);
      chk("sb_addr", bus0.data_addr, 32'h1FC0_0002);
      advance();
    end
    aok = 0; dok = 1; rdat = 32'h0000_1234;
    settle(); chk("sb_stall_wait", stall0, 1'b1); advance();
    dok = 0;
    settle(); chk("sb_stall_released", stall0, 1'b0); advance();
    en = 0; settle(); advance();

    // exception on the instruction: nothing goes to the bus
    set_m(1, 4'h0, 2'd2, 32'h0000_0102, 32'h0, 1); aok = 1;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("exc_req", bus0.data_req, 1'b0);
      chk("exc_stall", stall0, 1'b0);
      advance();
    end
    quiet(); en = 0; exc = 0; settle(); advance();

    // load completes while the pipe is held elsewhere
    set_m(1, 4'h0, 2'd2, 32'h0000_0200, 32'h0, 0); aok = 1;
    settle(); advance();
    aok = 0; dok = 1; rdat = 32'hCAFE_F00D; pstall = 1;
    settle(); advance();
    dok = 0; rdat = 32'h1111_1111;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("pst_stall", stall0, 1'b0);
      chk("pst_req", bus0.data_req, 1'b0);
      chk("pst_rdata", rd0, 32'hCAFE_F00D);
      advance();
    end
    pstall = 0;
    settle(); chk("pst_release_req", bus0.data_req, 1'b0); advance();
    en = 0; settle(); chk("pst_idle_req", bus0.data_req, 1'b0); advance();

    // flush during WAIT: bus completes, result discarded
    set_m(1, 4'h0, 2'd2, 32'h0000_0300, 32'h0, 0); aok = 1;
    settle(); advance();
    aok = 0; flush = 1;
    settle(); chk("fl_stall0", stall0, 1'b1); advance();
    flush = 0;
    settle(); chk("fl_stall1", stall0, 1'b1); advance();
    dok = 1; rdat = 32'h7777_0000;
    settle(); chk("fl_stall2", stall0, 1'b1); advance();
    dok = 0; en = 0;
    settle(); chk("fl_no_done", stall0, 1'b0); advance();
    en = 1; addr = 32'h0000_0304;
    settle(); chk("fl_next_req", bus0.data_req, 1'b1); aok = 1; advance();
    aok = 0; dok = 1; rdat = 32'h0;
    settle(); advance();
    dok = 0; settle(); advance();
    en = 0; settle(); advance();

    // reset in WAIT
    set_m(1, 4'h0, 2'd2, 32'h8000_0010, 32'h0, 0); aok = 1;
    settle(); advance();
    aok = 0; rst = 1;
    settle();
    chk("rst_req", bus0.data_req, 1'b0);
    chk("rst_stall", stall0, 1'b0);
    advance();
    rst = 0; en = 0; dok = 1; rdat = 32'hBAD0_BAD0;
    settle(); advance();
    dok = 0;
    settle(); chk("rst_late_dok", rd0, 32'h0); advance();

    // randomized traffic
    quiet();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(199) == 0);
      if (!m_busy && !m_done) begin
        en    = ($urandom_range(2) != 0);
        sel   = ($urandom_range(1) != 0) ? 4'($urandom_range(15, 1)) : 4'd0;
        size  = 2'($urandom_range(2));
        addr  = {segs[$urandom_range(5)], 28'($urandom)};
        wdata = $urandom;
        exc   = ($urandom_range(7) == 0);
      end
      flush  = ($urandom_range(9) == 0);
      pstall = ($urandom_range(2) == 0);
      aok    = model_req() ? 1'($urandom_range(1)) : 1'b0;
      if (m_busy && m_acc && !rst) dok = ($urandom_range(2) == 0);
      else dok = model_req() && aok && ($urandom_range(3) == 0);
      rdat = $urandom;
      settle();
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
